// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared constants, FSM encoding and round-constant helper for
//               the AES-128 round sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

   localparam int AES_BLOCK_W   = 128;
   localparam int AES128_ROUNDS = 10;

   localparam logic [7:0] RCON_INIT = 8'h01;
   localparam logic [7:0] RCON_POLY = 8'h1B;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUND = 2'd1,
      ST_DRAIN = 2'd2
   } aes_state_t;

   // xtime in GF(2^8) reduced by the AES polynomial
   function automatic logic [7:0] rcon_next(input logic [7:0] rc);
      return {rc[6:0], 1'b0} ^ (rc[7] ? RCON_POLY : 8'h00);
   endfunction

endpackage
`default_nettype wire

// File: rtl/aes_round_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : aes_round_ctrl_if
// Description : Host-side request/response and core-side drive signals of the
//               AES-128 round sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface aes_round_ctrl_if;
   import aes_pkg::*;

   logic                   start;
   logic [AES_BLOCK_W-1:0] data_in;
   logic [AES_BLOCK_W-1:0] key_in;
   logic [AES_BLOCK_W-1:0] core_out;
   logic [AES_BLOCK_W-1:0] core_data;
   logic [AES_BLOCK_W-1:0] core_key;
   logic                   first_round;
   logic                   final_round;
   logic [7:0]             round_const;
   logic                   busy;
   logic                   done;
   logic [AES_BLOCK_W-1:0] data_out;

   modport master (
      output start, data_in, key_in, core_out,
      input  core_data, core_key, first_round, final_round, round_const,
             busy, done, data_out
   );

   modport slave (
      input  start, data_in, key_in, core_out,
      output core_data, core_key, first_round, final_round, round_const,
             busy, done, data_out
   );

endinterface
`default_nettype wire

// File: rtl/aes_rcon_gen.sv
`default_nettype none
// ============================================================================
// Module      : aes_rcon_gen
// Description : Registered AES round-constant generator (clear/load/advance).
// Revision    : 1.0 - initial release
// ============================================================================
module aes_rcon_gen
   import aes_pkg::*;
(
   input  wire logic       clk,
   input  wire logic       rst,
   input  wire logic       i_clear,
   input  wire logic       i_load,
   input  wire logic       i_advance,
   output logic [7:0]      o_rcon
);

   logic [7:0] r_rcon;

   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_rcon <= 8'h00;
      end else if (i_load) begin
         r_rcon <= RCON_INIT;
      end else if (i_advance) begin
         r_rcon <= rcon_next(r_rcon);
      end
   end

   assign o_rcon = r_rcon;

endmodule
`default_nettype wire

// File: rtl/aes_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : aes_round_ctrl
// Description : Sequences one plaintext/key pair through the iterative aes_128
//               core over 11 round cycles and captures the ciphertext.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_round_ctrl
   import aes_pkg::*;
#(
   parameter int NUM_ROUNDS = 10,
   parameter int CORE_LAT   = 1
)(
   input  wire logic       clk,
   input  wire logic       rst,
   aes_round_ctrl_if.slave bus
);

   generate
      if (NUM_ROUNDS != AES128_ROUNDS) begin : g_bad_rounds
         $error("aes_round_ctrl: NUM_ROUNDS must be 10");
      end
      if (CORE_LAT < 1 || CORE_LAT > 4) begin : g_bad_core_lat
         $error("aes_round_ctrl: CORE_LAT must be in 1..4");
      end
   endgenerate

   localparam logic [3:0] c_LAST_RND   = 4'(NUM_ROUNDS);
   localparam logic [1:0] c_DRAIN_INIT = 2'(CORE_LAT - 1);

   aes_state_t             r_state;
   logic [3:0]             r_rnd_cnt;
   logic [1:0]             r_drain;
   logic [AES_BLOCK_W-1:0] r_core_data;
   logic [AES_BLOCK_W-1:0] r_core_key;
   logic [AES_BLOCK_W-1:0] r_data_out;
   logic                   r_first_round;
   logic                   r_final_round;
   logic                   r_busy;
   logic                   r_done;

   logic                   w_in_round;
   logic                   w_rc_load;
   logic                   w_rc_adv;
   logic                   w_rc_clr;
   logic [7:0]             w_rcon;

   // The round-constant register lags the counter by one edge, in step with
   // the other registered core controls.
   assign w_in_round = (r_state == ST_ROUND);
   assign w_rc_load  = w_in_round && (r_rnd_cnt == 4'd1);
   assign w_rc_adv   = w_in_round && (r_rnd_cnt > 4'd1) && (r_rnd_cnt <= c_LAST_RND);
   assign w_rc_clr   = !(w_rc_load || w_rc_adv);

   aes_rcon_gen u_rcon_gen (
      .clk       (clk),
      .rst       (rst),
      .i_clear   (w_rc_clr),
      .i_load    (w_rc_load),
      .i_advance (w_rc_adv),
      .o_rcon    (w_rcon)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_rnd_cnt     <= 4'd0;
         r_drain       <= 2'd0;
         r_core_data   <= '0;
         r_core_key    <= '0;
         r_data_out    <= '0;
         r_first_round <= 1'b0;
         r_final_round <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         r_done        <= 1'b0;
         r_first_round <= 1'b0;
         r_final_round <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_busy <= 1'b0;
               if (bus.start) begin
                  r_core_data <= bus.data_in;
                  r_core_key  <= bus.key_in;
                  r_rnd_cnt   <= 4'd0;
                  r_busy      <= 1'b1;
                  r_state     <= ST_ROUND;
               end
            end
            ST_ROUND: begin
               r_busy        <= 1'b1;
               r_first_round <= (r_rnd_cnt == 4'd0);
               r_final_round <= (r_rnd_cnt == c_LAST_RND);
               if (r_rnd_cnt == c_LAST_RND) begin
                  r_drain <= c_DRAIN_INIT;
                  r_state <= ST_DRAIN;
               end else if (r_rnd_cnt > c_LAST_RND) begin
                  r_busy        <= 1'b0;
                  r_first_round <= 1'b0;
                  r_state       <= ST_IDLE;
               end else begin
                  r_rnd_cnt <= r_rnd_cnt + 4'd1;
               end
            end
            ST_DRAIN: begin
               r_busy <= 1'b1;
               if (r_drain == 2'd0) begin
                  r_data_out <= bus.core_out;
                  r_done     <= 1'b1;
                  r_busy     <= 1'b0;
                  r_state    <= ST_IDLE;
               end else begin
                  r_drain <= r_drain - 2'd1;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.core_data   = r_core_data;
   assign bus.core_key    = r_core_key;
   assign bus.first_round = r_first_round;
   assign bus.final_round = r_final_round;
   assign bus.round_const = w_rcon;
   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.data_out    = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_round_ctrl
// Description : Self-checking bench for aes_round_ctrl with an AES-128 core
//               stand-in and a cycle-level expected-output model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_round_ctrl;

   localparam int LAT = 1;
   localparam logic [7:0] RC_TAB [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                          8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
   localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] K3 = 128'hffeeddccbbaa99887766554433221100;
   localparam logic [127:0] P3 = 128'h0123456789abcdeffedcba9876543210;

   logic clk;
   logic rst;
   aes_round_ctrl_if bus ();

   aes_round_ctrl #(.NUM_ROUNDS(10), .CORE_LAT(LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_vec = 0;
   int n_err = 0;
   logic [7:0] sb [256];

   // ---------------- AES-128 reference ----------------
   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xt(aa);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      logic [15:0] d;
      d = {b, b} << n;
      return d[15:8];
   endfunction

   function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
      logic [7:0] s [16];
      logic [7:0] k [16];
      logic [7:0] t [16];
      logic [7:0] w [4];
      logic [7:0] rc;
      logic [7:0] a0, a1, a2, a3;
      logic [127:0] r;
      for (int i = 0; i < 16; i++) begin
         k[i] = key[127-8*i -: 8];
         s[i] = pt[127-8*i -: 8] ^ k[i];
      end
      rc = 8'h01;
      for (int rnd = 1; rnd <= 10; rnd++) begin
         w[0] = sb[k[13]] ^ rc;
         w[1] = sb[k[14]];
         w[2] = sb[k[15]];
         w[3] = sb[k[12]];
         for (int i = 0; i < 16; i++) begin
            if (i < 4) k[i] = k[i] ^ w[i];
            else       k[i] = k[i] ^ k[i-4];
         end
         rc = xt(rc);
         for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
               t[4*c+rr] = sb[s[4*((c+rr)%4)+rr]];
         for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            if (rnd < 10) begin
               s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
               s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
               s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
               s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end else begin
               s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
      end
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
      return r;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // ---------------- core stand-in: result valid during the final-round cycle ----------------
   initial begin
      bus.core_out = '0;
      forever begin
         @(negedge clk);
         bus.core_out = bus.final_round ? aes_enc(bus.core_data, bus.core_key)
                                        : {4{32'hdeadbeef}};
      end
   end

   // ---------------- timing model: outputs as a function of edges since acceptance ----------------
   int           e = 0;
   int           m_acc = 0;
   int           m_done_e = -1;
   bit           m_active = 1'b0;
   logic [127:0] m_cd = '0, m_ck = '0, m_dout = '0;

   initial begin
      forever begin
         @(posedge clk);
         e++;
         if (rst) begin
            m_active = 1'b0; m_cd = '0; m_ck = '0; m_dout = '0;
         end else if (m_active && e == m_acc + 11 + LAT) begin
            m_dout   = aes_enc(m_cd, m_ck);
            m_active = 1'b0;
            m_done_e = e;
         end else if (!m_active && bus.start) begin
            m_active = 1'b1;
            m_acc    = e;
            m_cd     = bus.data_in;
            m_ck     = bus.key_in;
         end
      end
   end

   initial begin
      int k;
      logic [7:0] exp_rc;
      forever begin
         @(negedge clk);
         if (e > 0) begin
            k = e - m_acc;
            exp_rc = 8'h00;
            if (m_active && k >= 2 && k <= 11) exp_rc = RC_TAB[k-2];
            chk("busy",        {127'd0, bus.busy},        {127'd0, m_active});
            chk("first_round", {127'd0, bus.first_round}, {127'd0, m_active && k == 1});
            chk("final_round", {127'd0, bus.final_round}, {127'd0, m_active && k == 11});
            chk("round_const", {120'd0, bus.round_const}, {120'd0, exp_rc});
            chk("done",        {127'd0, bus.done},        {127'd0, e == m_done_e});
            chk("data_out",    bus.data_out,              m_dout);
            chk("core_data",   bus.core_data,             m_cd);
            chk("core_key",    bus.core_key,              m_ck);
         end
      end
   end

   // ---------------- event monitor ----------------
   int n_first = 0, n_final = 0, n_done = 0;
   int e_first = 0, e_final = 0;
   initial begin
      forever begin
         @(negedge clk);
         if (bus.first_round === 1'b1) begin n_first++; e_first = e; end
         if (bus.final_round === 1'b1) begin n_final++; e_final = e; end
         if (bus.done === 1'b1) n_done++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic issue(input logic [127:0] p, input logic [127:0] kk, output int acc_e);
      bus.start = 1'b1; bus.data_in = p; bus.key_in = kk;
      step();
      acc_e = e;
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input string nm, input int maxc);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         if (bus.done === 1'b1) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      chk(nm, {127'd0, ok}, 128'd1);
   endtask

   initial begin
      int a, s_first, s_final, s_done;
      logic [127:0] blk_p [3];
      logic [127:0] blk_k [3];
      blk_p = '{P1, P2, P3};
      blk_k = '{K1, K2, K3};

      rst = 1'b1;
      bus.start = 1'b0; bus.data_in = '0; bus.key_in = '0;
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv;
         inv = 8'h00;
         if (x != 0) begin
            inv = 8'h01;
            for (int j = 0; j < 254; j++) inv = gmul(inv, 8'(x));
         end
         sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      end
      chk("model_vec_c1", aes_enc(P1, K1), C1);
      chk("model_vec_c2", aes_enc(P2, K2), C2);

      repeat (3) step();
      rst = 1'b0;

      // idle with start low
      repeat (20) step();
      chk("idle_busy",     {127'd0, bus.busy}, 128'd0);
      chk("idle_done_cnt", 128'(n_done), 128'd0);
      chk("idle_data_out", bus.data_out, 128'd0);

      // single block
      s_first = n_first; s_final = n_final; s_done = n_done;
      issue(P1, K1, a);
      wait_done("op1_done_seen", 30);
      chk("op1_latency",   128'(e - a), 128'd12);
      chk("op1_data_out",  bus.data_out, C1);
      repeat (3) step();
      chk("op1_first_cnt", 128'(n_first - s_first), 128'd1);
      chk("op1_final_cnt", 128'(n_final - s_final), 128'd1);
      chk("op1_fr_gap",    128'(e_final - e_first), 128'd10);
      chk("op1_done_cnt",  128'(n_done - s_done), 128'd1);

      // restarts while busy are ignored
      s_done = n_done;
      issue(P2, K2, a);
      while (e < a + 2) step();
      bus.start = 1'b1; bus.data_in = P3; bus.key_in = K3;
      step();
      bus.start = 1'b0;
      while (e < a + 7) step();
      bus.start = 1'b1; bus.data_in = P1; bus.key_in = K3;
      step();
      bus.start = 1'b0;
      wait_done("op2_done_seen", 30);
      chk("op2_data_out", bus.data_out, C2);
      repeat (15) step();
      chk("op2_done_cnt", 128'(n_done - s_done), 128'd1);

      // start held high for three blocks
      s_done = n_done;
      bus.start = 1'b1; bus.data_in = blk_p[0]; bus.key_in = blk_k[0];
      for (int i = 0; i < 3; i++) begin
         step();
         if (i < 2) begin
            bus.data_in = blk_p[i+1]; bus.key_in = blk_k[i+1];
         end
         wait_done("b2b_done_seen", 30);
         chk("b2b_data_out", bus.data_out, aes_enc(blk_p[i], blk_k[i]));
      end
      bus.start = 1'b0;
      repeat (15) step();
      chk("b2b_done_cnt", 128'(n_done - s_done), 128'd3);

      // reset mid-operation
      issue(P3, K3, a);
      while (e < a + 5) step();
      s_done = n_done;
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_busy",      {127'd0, bus.busy}, 128'd0);
      chk("rst_first",     {127'd0, bus.first_round}, 128'd0);
      chk("rst_final",     {127'd0, bus.final_round}, 128'd0);
      chk("rst_rc",        {120'd0, bus.round_const}, 128'd0);
      chk("rst_data_out",  bus.data_out, 128'd0);
      chk("rst_core_data", bus.core_data, 128'd0);
      repeat (15) step();
      chk("rst_no_done",   128'(n_done - s_done), 128'd0);
      issue(P1, K1, a);
      wait_done("post_rst_done_seen", 30);
      chk("post_rst_latency",  128'(e - a), 128'd12);
      chk("post_rst_data_out", bus.data_out, C1);
      repeat (3) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Upstream sequencer for the iterative aes_128 core.
- Accepts one plaintext/key pair per start pulse, latches it, and drives the core's data, key, first-round, final-round and round-constant inputs over 11 round cycles.
- Captures the core's ciphertext after the pipeline drains and presents it with a one-cycle done pulse.
- Sits between the host/capture interface registers and aes_128.

Parameters:
- NUM_ROUNDS, 10, number of cipher rounds after the initial round; fixed at 10 for AES-128, and any other value is a synthesis error.
- CORE_LAT, 1, cycles from the final_round cycle to valid core_out; legal range 1..4.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to encrypt; sampled only while busy=0.
- data_in  in  128  plaintext, latched on accepted start.
- key_in  in  128  cipher key, latched on accepted start.
- core_out  in  128  ciphertext/state from aes_128 out.
- core_data  out  128  latched plaintext to aes_128 data.
- core_key  out  128  latched key to aes_128 key.
- first_round  out  1  to aes_128 firstRound.
- final_round  out  1  to aes_128 final_round.
- round_const  out  8  to aes_128 round_const.
- busy  out  1  high while an encryption is in flight.
- done  out  1  one-cycle pulse when data_out is updated.
- data_out  out  128  captured ciphertext; held until the next capture.

Behaviour:
- Reset (rst=1 at a clock edge):
  - All outputs go to 0 (core_data, core_key, first_round, final_round, round_const, busy, done, data_out).
  - The FSM goes to IDLE and the round counter rnd_cnt clears to 0.
  - Reset mid-operation aborts the operation: no done pulse, and data_out is cleared.
- FSM states: IDLE, ROUND, DRAIN, all registered.
- IDLE:
  - busy=0, first_round=0, final_round=0, round_const=0.
  - If start=1: latch data_in/key_in into core_data/core_key, set rnd_cnt=0, go to ROUND.
- ROUND (one cycle per rnd_cnt value, 0..10):
  - busy=1.
  - first_round=1 only when rnd_cnt=0.
  - final_round=1 only when rnd_cnt=NUM_ROUNDS.
  - round_const=8'h00 when rnd_cnt=0; otherwise rcon(rnd_cnt): 01,02,04,08,10,20,40,80,1B,36 for cnt 1..10.
  - first_round and final_round are never high in the same cycle.
  - At rnd_cnt=10, go to DRAIN with the drain counter = CORE_LAT-1.
- DRAIN:
  - busy=1, first_round=final_round=0, round_const=0.
  - When the drain counter reaches 0: data_out<=core_out, done<=1, go to IDLE.
  - Otherwise decrement the drain counter.
- done behaviour:
  - done is high for exactly one cycle, and that cycle is already IDLE with busy=0.
  - A start asserted in the done cycle is accepted, giving back-to-back operation.
- Latency: start sampled at edge T →
  - first_round visible after T+1;
  - final_round after T+11;
  - done and data_out valid after T+11+CORE_LAT (T+12 by default).
- Throughput: one block per 11+CORE_LAT cycles.
- start while busy=1 is ignored: not queued, and data_in/key_in changes have no effect.
- core_data and core_key are stable for the whole operation and change only on an accepted start.
- Round-constant arithmetic:
  - rc_next = {rc[6:0],1'b0} ^ (rc[7] ? 8'h1B : 8'h00).
  - The sequence is reloaded to 8'h01 when entering rnd_cnt=1.
  - No wrap beyond 36 is ever reached.
- rnd_cnt is 4 bits; values 11..15 are unreachable and, if ever decoded, force IDLE.

Decomposition:
- Package aes_pkg holds:
  - the FSM state encoding (IDLE/ROUND/DRAIN);
  - RCON_INIT=8'h01, RCON_POLY=8'h1B;
  - AES128_ROUNDS=10;
  - the 128-bit block width constant.
- One sub-module, aes_rcon_gen: registered round-constant generator with load/advance inputs and an 8-bit output. It is reusable by a future on-the-fly key expansion block.

Test Plan:
- Reset then idle → all outputs 0; hold start=0 for 20 cycles and busy/done stay 0.
- start with key=000102030405060708090a0b0c0d0e0f, data=00112233445566778899aabbccddeeff, driving real aes_128 → done at T+12; data_out=69c4e0d86a7b0430d8cdb78070b4c55a.
- Same start, monitoring control outputs → first_round high exactly 1 cycle, final_round high exactly 1 cycle 10 cycles later; round_const trace 00,01,02,04,08,10,20,40,80,1B,36.
- start re-pulsed at cycles T+3 and T+8 with different data → ignored; exactly one done, ciphertext of the first block only.
- start held high continuously for 3 blocks → three done pulses spaced 12 cycles apart, each data_out matching its own block; busy low only in the done cycles.
- rst asserted at rnd_cnt=5 → the next cycle shows all outputs 0 and state IDLE, no done; a new start then completes normally at T+12.
